// File: rtl/mesh_frame_sequencer.sv
// mesh_frame_sequencer: takes one 2-bit/pixel frame at a time, clears the
// contour mesh, runs it until the contour output stops changing (or a cycle
// budget runs out), then holds the captured contour on a valid/ready port.
module mesh_frame_sequencer #(
   parameter int COLS       = 26,
   parameter int ROWS       = 18,
   parameter int PIX_W      = 2,
   parameter int SETTLE_MAX = 16,
   parameter int STABLE_N   = 2
) (
   input  logic                          clk,
   input  logic                          rst,
   // frame input port
   input  logic                          frm_valid,
   output logic                          frm_ready,
   input  logic [COLS*ROWS*PIX_W-1:0]    frm_data,
   input  logic                          frm_algo,
   // mesh interface
   output logic [COLS*ROWS*PIX_W-1:0]    mesh_inp,
   output logic                          mesh_high,
   output logic                          mesh_algo,
   input  logic [COLS*ROWS-1:0]          mesh_contour,
   // result port
   output logic                          res_valid,
   input  logic                          res_ready,
   output logic [COLS*ROWS-1:0]          res_contour,
   output logic                          res_algo,
   output logic                          res_timeout,
   output logic                          busy
);

   localparam int FRM_W = COLS*ROWS*PIX_W;
   localparam int CON_W = COLS*ROWS;
   localparam int CNT_W = $clog2(SETTLE_MAX+1);
   localparam int STB_W = $clog2(STABLE_N+1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_CLEAR = 2'd1,
      S_RUN   = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t              r_state;
   state_t              w_state_n;

   logic [FRM_W-1:0]    r_mesh_inp;
   logic                r_mesh_high;
   logic                r_mesh_algo;
   logic [CON_W-1:0]    r_prev;
   logic [CNT_W-1:0]    r_cnt;
   logic [STB_W-1:0]    r_stab;
   logic                r_res_valid;
   logic [CON_W-1:0]    r_res_contour;
   logic                r_res_algo;
   logic                r_res_timeout;

   logic                w_accept;
   logic                w_release;
   logic [STB_W-1:0]    w_stab_n;
   logic                w_conv;
   logic                w_tmo;

   // Handshakes: a frame is only taken in IDLE, and never while reset is high.
   assign frm_ready = (r_state == S_IDLE) & ~rst;
   assign w_accept  = frm_valid & frm_ready;
   assign w_release = r_res_valid & res_ready;

   // Convergence tracking: the first RUN cycle has no previous sample to compare.
   always_comb begin
      w_stab_n = '0;
      if ((r_cnt != '0) && (mesh_contour == r_prev))
         w_stab_n = r_stab + STB_W'(1);
   end

   assign w_conv = (w_stab_n == STB_W'(STABLE_N));
   assign w_tmo  = (r_cnt == CNT_W'(SETTLE_MAX-1));

   // State register.
   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_n;
   end

   // Next-state logic.
   always_comb begin
      w_state_n = r_state;
      case (r_state)
         S_IDLE:  if (w_accept)        w_state_n = S_CLEAR;
         S_CLEAR:                      w_state_n = S_RUN;
         S_RUN:   if (w_conv || w_tmo) w_state_n = S_DONE;
         S_DONE:  if (w_release)       w_state_n = S_IDLE;
         default:                      w_state_n = S_IDLE;
      endcase
   end

   // Datapath: frame latch, mesh enable, run counters and result capture.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_mesh_inp    <= '0;
         r_mesh_high   <= 1'b0;
         r_mesh_algo   <= 1'b0;
         r_prev        <= '0;
         r_cnt         <= '0;
         r_stab        <= '0;
         r_res_valid   <= 1'b0;
         r_res_contour <= '0;
         r_res_algo    <= 1'b0;
         r_res_timeout <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_mesh_inp  <= frm_data;
                  r_mesh_algo <= frm_algo;
                  r_mesh_high <= 1'b0;
               end
            end
            S_CLEAR: begin
               // mesh has seen one cycle with high low; start it running
               r_mesh_high <= 1'b1;
               r_cnt       <= '0;
               r_stab      <= '0;
            end
            S_RUN: begin
               r_prev <= mesh_contour;
               r_cnt  <= r_cnt + CNT_W'(1);
               r_stab <= w_stab_n;
               if (w_conv || w_tmo) begin
                  // convergence takes priority when both fire together
                  r_res_contour <= mesh_contour;
                  r_res_algo    <= r_mesh_algo;
                  r_res_valid   <= 1'b1;
                  r_res_timeout <= ~w_conv;
               end
            end
            S_DONE: begin
               // mesh_high stays up so the mesh output remains frozen
               if (w_release) begin
                  r_res_valid <= 1'b0;
                  r_mesh_high <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign mesh_inp    = r_mesh_inp;
   assign mesh_high   = r_mesh_high;
   assign mesh_algo   = r_mesh_algo;
   assign res_valid   = r_res_valid;
   assign res_contour = r_res_contour;
   assign res_algo    = r_res_algo;
   assign res_timeout = r_res_timeout;
   assign busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_mesh_frame_sequencer.sv
// Bench for mesh_frame_sequencer: drives frames and per-cycle contour
// sequences, predicts result timing/content with a sliding-window model.
module tb_mesh_frame_sequencer;

   localparam int FW = 936;
   localparam int CW = 468;
   localparam int SM = 16;
   localparam int SN = 2;

   typedef logic [CW-1:0] seq_t [SM];

   logic          clk = 1'b0;
   logic          rst;
   logic          frm_valid;
   logic          frm_ready;
   logic [FW-1:0] frm_data;
   logic          frm_algo;
   logic [FW-1:0] mesh_inp;
   logic          mesh_high;
   logic          mesh_algo;
   logic [CW-1:0] mesh_contour;
   logic          res_valid;
   logic          res_ready;
   logic [CW-1:0] res_contour;
   logic          res_algo;
   logic          res_timeout;
   logic          busy;

   int n_tot = 0;
   int n_bad = 0;

   mesh_frame_sequencer dut (
      .clk(clk), .rst(rst),
      .frm_valid(frm_valid), .frm_ready(frm_ready), .frm_data(frm_data), .frm_algo(frm_algo),
      .mesh_inp(mesh_inp), .mesh_high(mesh_high), .mesh_algo(mesh_algo), .mesh_contour(mesh_contour),
      .res_valid(res_valid), .res_ready(res_ready), .res_contour(res_contour),
      .res_algo(res_algo), .res_timeout(res_timeout), .busy(busy)
   );

   always #5 clk = ~clk;

   // comparison: counts every call, reports low 128 bits on mismatch
   task automatic chk(input string tag, input logic [FW-1:0] got, input logic [FW-1:0] exp);
      n_tot++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got[127:0], exp[127:0]);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [CW-1:0] rcon();
      logic [479:0] t;
      for (int i = 0; i < 15; i++) t[i*32 +: 32] = $urandom();
      return t[CW-1:0];
   endfunction

   function automatic logic [FW-1:0] rfrm();
      logic [959:0] t;
      for (int i = 0; i < 30; i++) t[i*32 +: 32] = $urandom();
      return t[FW-1:0];
   endfunction

   // Reference: result is taken at the first RUN index k where the last SN+1
   // samples are identical; otherwise at the final budget index as a timeout.
   function automatic int model_k(input seq_t s, output logic tmo);
      for (int k = SN; k < SM; k++) begin
         bit same = 1'b1;
         for (int j = 1; j <= SN; j++) if (s[k-j] !== s[k]) same = 1'b0;
         if (same) begin
            tmo = 1'b0;
            return k;
         end
      end
      tmo = 1'b1;
      return SM-1;
   endfunction

   // mode 0 const, 1 toggle, 2 change at index 3 after noise, 3 random a/b, 4 change at random p
   function automatic seq_t mk_seq(input int mode);
      seq_t s;
      logic [CW-1:0] a, b;
      int p;
      a = rcon();
      b = rcon();
      p = $urandom_range(0, SM-1);
      for (int k = 0; k < SM; k++) begin
         case (mode)
            0: s[k] = a;
            1: s[k] = k[0] ? b : a;
            2: s[k] = (k < 3) ? rcon() : b;
            3: s[k] = ($urandom_range(0, 1) != 0) ? b : a;
            default: s[k] = (k < p) ? a : b;
         endcase
      end
      return s;
   endfunction

   task automatic run_frame(input logic algo, input int mode, input int hold);
      seq_t s;
      logic [FW-1:0] data;
      logic exp_tmo;
      int kexp;
      s    = mk_seq(mode);
      kexp = model_k(s, exp_tmo);
      data = rfrm();
      // cycle T: offer frame
      frm_valid = 1'b1; frm_data = data; frm_algo = algo;
      chk("idle_rdy", frm_ready, 1'b1);
      tick();
      // T+1: CLEAR
      frm_valid = 1'b0; frm_data = rfrm(); frm_algo = ~algo;
      chk("clr_high", mesh_high, 1'b0);
      chk("clr_inp", mesh_inp, data);
      chk("clr_algo", mesh_algo, algo);
      chk("clr_busy", busy, 1'b1);
      tick();
      // T+2+k: RUN
      for (int k = 0; k <= kexp; k++) begin
         mesh_contour = s[k];
         chk("run_high", mesh_high, 1'b1);
         chk("run_rv", res_valid, 1'b0);
         tick();
      end
      // T+3+kexp: result must be up
      mesh_contour = rcon();
      chk("res_valid", res_valid, 1'b1);
      chk("res_contour", res_contour, s[kexp]);
      chk("res_algo", res_algo, algo);
      chk("res_timeout", res_timeout, exp_tmo);
      chk("done_rdy", frm_ready, 1'b0);
      // back-pressure: everything holds, frame offers ignored
      for (int h = 0; h < hold; h++) begin
         frm_valid = ($urandom_range(0, 1) != 0);
         frm_data = rfrm();
         mesh_contour = rcon();
         tick();
         chk("hold_rv", res_valid, 1'b1);
         chk("hold_con", res_contour, s[kexp]);
         chk("hold_high", mesh_high, 1'b1);
         chk("hold_rdy", frm_ready, 1'b0);
      end
      frm_valid = 1'b0;
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      chk("rel_rv", res_valid, 1'b0);
      chk("rel_busy", busy, 1'b0);
      chk("rel_high", mesh_high, 1'b0);
      chk("rel_rdy", frm_ready, 1'b1);
      chk("rel_con", res_contour, s[kexp]);
      chk("rel_inp", mesh_inp, data);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_rdy"}, frm_ready, 1'b0);
      chk({tag, "_inp"}, mesh_inp, '0);
      chk({tag, "_high"}, mesh_high, 1'b0);
      chk({tag, "_algo"}, mesh_algo, 1'b0);
      chk({tag, "_rv"}, res_valid, 1'b0);
      chk({tag, "_con"}, res_contour, '0);
      chk({tag, "_ralgo"}, res_algo, 1'b0);
      chk({tag, "_tmo"}, res_timeout, 1'b0);
      chk({tag, "_busy"}, busy, 1'b0);
   endtask

   // reset mid-operation: wc=0 CLEAR, wc=2 RUN, wc=4 DONE (constant contour)
   task automatic rst_mid(input string tag, input int wc);
      frm_valid = 1'b1; frm_data = rfrm(); frm_algo = 1'b1;
      tick();
      frm_valid = 1'b0;
      mesh_contour = rcon();
      repeat (wc) tick();
      chk({tag, "_pre_busy"}, busy, 1'b1);
      chk({tag, "_pre_rv"}, res_valid, (wc == 4) ? 1'b1 : 1'b0);
      rst = 1'b1;
      tick();
      chk_all_zero(tag);
      rst = 1'b0;
      #1;
      chk({tag, "_rdy_after"}, frm_ready, 1'b1);
      res_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         chk({tag, "_stale_rv"}, res_valid, 1'b0);
      end
      res_ready = 1'b0;
   endtask

   initial begin
      logic [FW-1:0] da, db;
      logic [CW-1:0] ca, cb;
      int acc, last_acc, idx, w;
      rst = 1'b1; frm_valid = 1'b0; frm_data = '0; frm_algo = 1'b0;
      mesh_contour = '0; res_ready = 1'b0;
      tick(); tick();
      chk_all_zero("reset");
      rst = 1'b0;
      #1;
      chk("reset_rdy", frm_ready, 1'b1);

      // directed: stable, toggling, late change with back-pressure
      run_frame(1'b1, 0, 0);
      run_frame(1'b0, 1, 0);
      run_frame(1'b1, 2, 10);

      // randomized frames
      for (int i = 0; i < 12; i++)
         run_frame(1'($urandom_range(0, 1)), $urandom_range(0, 4), $urandom_range(0, 3));

      // back-to-back alternating frames with stable contours
      da = rfrm(); db = rfrm(); ca = rcon(); cb = rcon();
      acc = 0; last_acc = -1;
      res_ready = 1'b1; frm_valid = 1'b1;
      for (int cyc = 0; cyc < 40; cyc++) begin
         frm_data = acc[0] ? db : da;
         frm_algo = acc[0];
         idx = acc - 1;
         mesh_contour = idx[0] ? cb : ca;
         if (res_valid) begin
            chk("b2b_con", res_contour, idx[0] ? cb : ca);
            chk("b2b_algo", res_algo, idx[0]);
         end
         if (frm_ready) begin
            if (last_acc >= 0) chk("b2b_gap", cyc - last_acc, 6);
            last_acc = cyc;
            acc++;
         end
         tick();
      end
      frm_valid = 1'b0;
      w = 0;
      while (busy && w < 40) begin
         tick();
         w++;
      end
      chk("b2b_drain", busy, 1'b0);
      chk("b2b_count", acc, 7);
      res_ready = 1'b0;

      // reset during CLEAR, RUN and DONE
      rst_mid("rclr", 0);
      rst_mid("rrun", 2);
      rst_mid("rdone", 4);

      // sequencer still works afterwards
      run_frame(1'b1, 0, 1);

      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end

endmodule
